// File: rtl/deserializer_pkg.sv
// deserializer_pkg: FSM encodings and default word length shared by the serdes blocks
package deserializer_pkg;
   localparam logic [0:0] SER_IDLE   = 1'b0;
   localparam logic [0:0] SER_SHIFT  = 1'b1;
   localparam int         SER_LENGTH = 24;
endpackage

// File: rtl/deserializer.sv
// deserializer: LSB-first serial-to-parallel converter with start framing, valid/ready output and sticky error flags
module deserializer
   import deserializer_pkg::*;
#(
   parameter int LENGTH = SER_LENGTH
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_din,
   input  logic              i_din_start,
   output logic [LENGTH-1:0] ov_dout,
   output logic              o_dout_valid,
   input  logic              i_dout_ready,
   output logic              o_busy,
   output logic              o_overrun,
   output logic              o_frame_err
);
   localparam int CNT_W = $clog2(LENGTH + 1);
   logic [0:0]        state;
   logic [CNT_W-1:0]  count;
   logic [LENGTH-1:0] shift_reg;
   logic [LENGTH-1:0] word;
   logic              in_shift;
   logic              take;
   logic              last;
   logic              can_load;
   assign in_shift = (state == SER_SHIFT);
   assign word     = {i_din, shift_reg[LENGTH-1:1]};
   assign take     = i_en && (in_shift || i_din_start);
   assign last     = i_en && in_shift && (count == CNT_W'(LENGTH - 1));
   assign can_load = !o_dout_valid || i_dout_ready;
   assign o_busy   = in_shift;
   // input side: a start marker (in IDLE or mid-frame) restarts the count at 1; the last bit returns to IDLE
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= SER_IDLE;
         count       <= '0;
         shift_reg   <= '0;
         o_frame_err <= 1'b0;
      end else begin
         if (take) shift_reg <= word;
         if (last) begin
            state <= SER_IDLE;
            count <= '0;
         end else if (take) begin
            state <= SER_SHIFT;
            count <= i_din_start ? CNT_W'(1) : count + CNT_W'(1);
         end
         if (i_en && in_shift && i_din_start) o_frame_err <= 1'b1;
      end
   end
   // output side: load a completed word when the register is free or drained this edge, otherwise drop it and flag overrun
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ov_dout      <= '0;
         o_dout_valid <= 1'b0;
         o_overrun    <= 1'b0;
      end else if (last && can_load) begin
         ov_dout      <= word;
         o_dout_valid <= 1'b1;
      end else begin
         if (last) o_overrun <= 1'b1;
         if (o_dout_valid && i_dout_ready) o_dout_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: table-driven and hand-sequenced checks of deserializer with a word scoreboard
module tb_deserializer;
   localparam int L = 24;
   typedef struct {
      logic [L-1:0] word;
      int           gap;
      logic [L-1:0] exp;
   } vec_t;
   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_en = 1'b0;
   logic         i_din = 1'b0;
   logic         i_din_start = 1'b0;
   logic         i_dout_ready = 1'b0;
   logic [L-1:0] ov_dout;
   logic         o_dout_valid;
   logic         o_busy;
   logic         o_overrun;
   logic         o_frame_err;
   int           total = 0;
   int           bad = 0;
   bit           mon_en = 1'b0;
   logic [L-1:0] sb[$];
   vec_t         vecs[6];
   logic [L-1:0] w;
   always #5 i_clk = ~i_clk;
   deserializer #(.LENGTH(L)) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_en(i_en),
      .i_din(i_din),
      .i_din_start(i_din_start),
      .ov_dout(ov_dout),
      .o_dout_valid(o_dout_valid),
      .i_dout_ready(i_dout_ready),
      .o_busy(o_busy),
      .o_overrun(o_overrun),
      .o_frame_err(o_frame_err)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   // one clock: scoreboard sampled on the falling edge, inputs change 1 time unit after the rising edge
   task automatic tick();
      @(negedge i_clk);
      if (mon_en && o_dout_valid && i_dout_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stray_word: got %0h want no word", ov_dout);
         end else begin
            chk("sb_word", 32'(ov_dout), 32'(sb.pop_front()));
         end
      end
      @(posedge i_clk);
      #1;
   endtask
   task automatic send_range(input logic [L-1:0] wd, input int lo, input int hi, input int gap);
      for (int i = lo; i < hi; i++) begin
         i_en = 1'b1;
         i_din = wd[i];
         i_din_start = (i == 0);
         tick();
         for (int g = 0; g < gap; g++) begin
            i_en = 1'b0;
            i_din = 1'($urandom);
            i_din_start = 1'($urandom);
            tick();
         end
      end
      i_en = 1'b0;
      i_din_start = 1'b0;
   endtask
   task automatic do_reset();
      mon_en = 1'b0;
      i_rst_n = 1'b0;
      i_en = 1'b0;
      i_din_start = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
      sb.delete();
      mon_en = 1'b1;
   endtask
   initial begin
      vecs[0] = '{24'h000000, 0, 24'h000000};
      vecs[1] = '{24'hFFFFFF, 0, 24'hFFFFFF};
      vecs[2] = '{24'h800001, 0, 24'h800001};
      vecs[3] = '{24'h555555, 1, 24'h555555};
      vecs[4] = '{24'hAAAAAA, 2, 24'hAAAAAA};
      vecs[5] = '{24'h13579B, 0, 24'h13579B};
      i_dout_ready = 1'b1;
      do_reset();
      chk("rst_dout", 32'(ov_dout), 0);
      chk("rst_valid", 32'(o_dout_valid), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_overrun", 32'(o_overrun), 0);
      chk("rst_frame_err", 32'(o_frame_err), 0);
      // single word, continuous enable: valid on the last-bit edge for exactly one cycle
      sb.push_back(24'hA5C3F1);
      send_range(24'hA5C3F1, 0, L, 0);
      chk("t1_valid", 32'(o_dout_valid), 1);
      chk("t1_dout", 32'(ov_dout), 32'hA5C3F1);
      chk("t1_busy", 32'(o_busy), 0);
      tick();
      chk("t1_valid_drop", 32'(o_dout_valid), 0);
      // sparse enable with a long stall mid-frame
      sb.push_back(24'hA5C3F1);
      send_range(24'hA5C3F1, 0, 9, 2);
      chk("t2_busy_mid", 32'(o_busy), 1);
      repeat (5) tick();
      chk("t2_busy_hold", 32'(o_busy), 1);
      chk("t2_valid_hold", 32'(o_dout_valid), 0);
      send_range(24'hA5C3F1, 9, L, 2);
      chk("t2_dout", 32'(ov_dout), 32'hA5C3F1);
      tick();
      // table of back-to-back and gapped frames
      for (int i = 0; i < 6; i++) begin
         sb.push_back(vecs[i].exp);
         send_range(vecs[i].word, 0, L, vecs[i].gap);
      end
      tick();
      chk("tbl_drained", 32'(sb.size()), 0);
      chk("tbl_overrun", 32'(o_overrun), 0);
      chk("tbl_frame_err", 32'(o_frame_err), 0);
      // overrun: second word dropped while output is full
      i_dout_ready = 1'b0;
      sb.push_back(24'h000001);
      send_range(24'h000001, 0, L, 0);
      send_range(24'hFFFFFE, 0, L, 0);
      tick();
      chk("t3_dout", 32'(ov_dout), 32'h000001);
      chk("t3_valid", 32'(o_dout_valid), 1);
      chk("t3_overrun", 32'(o_overrun), 1);
      i_dout_ready = 1'b1;
      tick();
      chk("t3_valid_drop", 32'(o_dout_valid), 0);
      chk("t3_overrun_sticky", 32'(o_overrun), 1);
      // resync: partial word discarded, restart delivers only the new word
      do_reset();
      send_range(24'h123456, 0, 10, 0);
      sb.push_back(24'h654321);
      send_range(24'h654321, 0, L, 0);
      chk("t4_dout", 32'(ov_dout), 32'h654321);
      chk("t4_frame_err", 32'(o_frame_err), 1);
      chk("t4_overrun", 32'(o_overrun), 0);
      tick();
      // start marker on the final bit completes the word and flags a frame error
      do_reset();
      w = 24'hC0FFEE;
      sb.push_back(w);
      send_range(w, 0, L - 1, 0);
      i_en = 1'b1;
      i_din = w[L-1];
      i_din_start = 1'b1;
      tick();
      i_en = 1'b0;
      i_din_start = 1'b0;
      chk("tl_dout", 32'(ov_dout), 32'hC0FFEE);
      chk("tl_busy", 32'(o_busy), 0);
      chk("tl_frame_err", 32'(o_frame_err), 1);
      tick();
      // reset mid-frame discards the partial word
      do_reset();
      send_range(24'hABCDEF, 0, 12, 0);
      chk("t5_busy_pre", 32'(o_busy), 1);
      do_reset();
      chk("t5_rst_dout", 32'(ov_dout), 0);
      chk("t5_rst_valid", 32'(o_dout_valid), 0);
      chk("t5_rst_busy", 32'(o_busy), 0);
      sb.push_back(24'h0F0F0F);
      send_range(24'h0F0F0F, 0, L, 0);
      chk("t5_dout", 32'(ov_dout), 32'h0F0F0F);
      tick();
      // random stream with irregular bit-rate enable
      do_reset();
      for (int i = 0; i < 100; i++) begin
         w = L'($urandom);
         sb.push_back(w);
         send_range(w, 0, L, int'($urandom_range(0, 2)));
      end
      tick();
      tick();
      chk("t6_drained", 32'(sb.size()), 0);
      chk("t6_overrun", 32'(o_overrun), 0);
      chk("t6_frame_err", 32'(o_frame_err), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
